// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
// Default geometry and the two-state FSM encoding.
package regfile_ctrl_pkg;

    localparam int DEF_NREQ   = 3;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant search, purely combinational.
// Returns a one-hot grant and its index, starting the search at i_ptr.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_j;

    // First set request at or after the pointer, wrapping around.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port: init sweep, then
// round-robin sharing among writeback requesters.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int                 NREQ       = DEF_NREQ,
    parameter int                 ADDR_W     = DEF_ADDR_W,
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NREQ-1:0]        REQ_VALID,
    input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0] REQ_DATA,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic                   CLEAR,
    output logic                   WE3,
    output logic [ADDR_W-1:0]      A3,
    output logic [DATA_W-1:0]      WD3,
    output logic                   INIT_BUSY
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [PTR_W-1:0]    r_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_a3;
    logic [DATA_W-1:0]   r_wd3;
    logic                r_last_sweep;

    logic [NREQ-1:0]     w_req;
    logic [NREQ-1:0]     w_grant;
    logic [PTR_W-1:0]    w_idx;
    logic                w_any;
    logic                w_cnt_last;

    assign w_cnt_last = (r_cnt == {ADDR_W{1'b1}});

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (PTR_W)
    ) u_rr (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next state: sweep ends after the last address; CLEAR re-enters the sweep.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_INIT: begin
                if (CLEAR)           w_state_nxt = ST_INIT;
                else if (w_cnt_last) w_state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (CLEAR) w_state_nxt = ST_INIT;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Requests only reach the arbiter in ST_ARB with no CLEAR pending.
    always_comb begin
        w_req     = '0;
        REQ_READY = w_grant;
        INIT_BUSY = (r_state == ST_INIT) | r_last_sweep;
        if (r_state == ST_ARB && !CLEAR) w_req = REQ_VALID;
    end

    // Sweep counter, rr pointer and registered write-port outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_we         <= 1'b0;
            r_a3         <= '0;
            r_wd3        <= '0;
            r_last_sweep <= 1'b0;
        end else begin
            r_last_sweep <= 1'b0;
            if (CLEAR) begin
                r_cnt <= '0;
                r_we  <= 1'b0;
            end else if (r_state == ST_INIT) begin
                r_we         <= 1'b1;
                r_a3         <= r_cnt;
                r_wd3        <= INIT_VALUE;
                r_cnt        <= r_cnt + 1'b1;
                r_last_sweep <= w_cnt_last;
            end else if (w_any) begin
                r_we  <= 1'b1;
                r_a3  <= REQ_ADDR[w_idx*ADDR_W +: ADDR_W];
                r_wd3 <= REQ_DATA[w_idx*DATA_W +: DATA_W];
                r_ptr <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign WE3 = r_we;
    assign A3  = r_a3;
    assign WD3 = r_wd3;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed steps
// followed by random traffic checked against a round-robin model.
module tb_regfile_write_arbiter;
    import regfile_ctrl_pkg::*;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << ADDR_W;

    logic                   CLK = 1'b0;
    logic                   RST_N;
    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ*ADDR_W-1:0] REQ_ADDR;
    logic [NREQ*DATA_W-1:0] REQ_DATA;
    logic [NREQ-1:0]        REQ_READY;
    logic                   CLEAR;
    logic                   WE3;
    logic [ADDR_W-1:0]      A3;
    logic [DATA_W-1:0]      WD3;
    logic                   INIT_BUSY;

    logic [ADDR_W-1:0] t_addr [NREQ];
    logic [DATA_W-1:0] t_data [NREQ];

    int n_assert = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(
        .NREQ       (NREQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .INIT_VALUE ('0)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .CLEAR     (CLEAR),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .INIT_BUSY (INIT_BUSY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        REQ_ADDR = '0;
        REQ_DATA = '0;
        for (int i = 0; i < NREQ; i++) begin
            REQ_ADDR[i*ADDR_W +: ADDR_W] = t_addr[i];
            REQ_DATA[i*DATA_W +: DATA_W] = t_data[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_wr(input string tag, input int a, input logic [DATA_W-1:0] d);
        chk({tag, ".we"}, 64'(WE3), 64'(1));
        chk({tag, ".a3"}, 64'(A3), 64'(a));
        chk({tag, ".wd3"}, 64'(WD3), 64'(d));
    endtask

    task automatic sweep_check(input string tag, input logic [NREQ-1:0] last_ready);
        for (int i = 0; i < NREGS; i++) begin
            tick();
            chk_wr(tag, i, '0);
            chk({tag, ".busy"}, 64'(INIT_BUSY), 64'(1));
            chk({tag, ".ready"}, 64'(REQ_READY),
                64'((i == NREGS - 1) ? last_ready : '0));
        end
    endtask

    // Reference model state for the random phase.
    bit                pend [NREQ];
    int                ptr_m;
    int                g;
    bit                e_we;
    logic [ADDR_W-1:0] e_a;
    logic [DATA_W-1:0] e_wd;
    logic [NREQ-1:0]   e_rdy;

    initial begin
        RST_N     = 1'b0;
        CLEAR     = 1'b0;
        REQ_VALID = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        #2;
        chk("rst.we", 64'(WE3), 64'(0));
        chk("rst.a3", 64'(A3), 64'(0));
        chk("rst.wd3", 64'(WD3), 64'(0));
        chk("rst.ready", 64'(REQ_READY), 64'(0));
        chk("rst.busy", 64'(INIT_BUSY), 64'(1));
        tick();
        tick();
        RST_N = 1'b1;

        // Power-on sweep.
        sweep_check("init", '0);
        tick();
        chk("init.end.we", 64'(WE3), 64'(0));
        chk("init.end.busy", 64'(INIT_BUSY), 64'(0));

        // Single requester 1.
        t_addr[1] = 5'd5;
        t_data[1] = 32'hDEADBEEF;
        REQ_VALID = 3'b010;
        #1;
        chk("single.ready", 64'(REQ_READY), 64'(3'b010));
        tick();
        REQ_VALID = '0;
        chk_wr("single", 5, 32'hDEADBEEF);

        // Move pointer to 0 via requester 2.
        t_addr[0] = 5'd10;
        t_addr[1] = 5'd11;
        t_addr[2] = 5'd12;
        t_data[0] = 32'h1111_0000;
        t_data[1] = 32'h2222_0001;
        t_data[2] = 32'h3333_0002;
        REQ_VALID = 3'b100;
        #1;
        chk("r2.ready", 64'(REQ_READY), 64'(3'b100));
        tick();
        chk_wr("r2", 12, 32'h3333_0002);

        // All three held: 0,1,2,0,1,2 back to back.
        REQ_VALID = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr.ready", 64'(REQ_READY), 64'(1 << (k % 3)));
            tick();
            chk_wr("rr", 10 + (k % 3), t_data[k % 3]);
        end
        REQ_VALID = '0;

        // Wrap search: pointer at 1 after a grant to 0, only 0 valid.
        REQ_VALID = 3'b001;
        #1;
        chk("wrap0.ready", 64'(REQ_READY), 64'(3'b001));
        tick();
        chk_wr("wrap0", 10, 32'h1111_0000);
        #1;
        chk("wrap1.ready", 64'(REQ_READY), 64'(3'b001));
        tick();
        chk_wr("wrap1", 10, 32'h1111_0000);
        REQ_VALID = 3'b111;
        #1;
        chk("ptr1.ready", 64'(REQ_READY), 64'(3'b010));
        tick();
        chk_wr("ptr1", 11, 32'h2222_0001);

        // CLEAR while requester 2 waits.
        REQ_VALID = 3'b100;
        CLEAR     = 1'b1;
        #1;
        chk("clr.ready", 64'(REQ_READY), 64'(0));
        tick();
        CLEAR = 1'b0;
        chk("clr.we", 64'(WE3), 64'(0));
        chk("clr.busy", 64'(INIT_BUSY), 64'(1));
        sweep_check("clr.sweep", 3'b100);
        tick();
        REQ_VALID = '0;
        chk_wr("clr.r2", 12, 32'h3333_0002);

        // Reset in the middle of a sweep.
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk("mid.a3", 64'(A3), 64'(i));
        end
        #1;
        RST_N = 1'b0;
        #1;
        chk("mid.rst.we", 64'(WE3), 64'(0));
        chk("mid.rst.a3", 64'(A3), 64'(0));
        chk("mid.rst.wd3", 64'(WD3), 64'(0));
        chk("mid.rst.busy", 64'(INIT_BUSY), 64'(1));
        tick();
        RST_N = 1'b1;
        sweep_check("mid.sweep", '0);
        tick();
        chk("mid.end.we", 64'(WE3), 64'(0));

        // Random traffic against the round-robin model.
        ptr_m = 0;
        e_we  = 1'b0;
        e_a   = 5'd31;
        e_wd  = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd.we", 64'(WE3), 64'(e_we));
            chk("rnd.a3", 64'(A3), 64'(e_a));
            chk("rnd.wd3", 64'(WD3), 64'(e_wd));
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    t_addr[i] = ADDR_W'($urandom);
                    t_data[i] = $urandom;
                end
                REQ_VALID[i] = pend[i];
            end
            #1;
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && pend[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            chk("rnd.ready", 64'(REQ_READY), 64'(e_rdy));
            if (g >= 0) begin
                e_we    = 1'b1;
                e_a     = t_addr[g];
                e_wd    = t_data[g];
                pend[g] = 1'b0;
                ptr_m   = (g + 1) % NREQ;
            end else begin
                e_we = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
